// File: rtl/pwm_carrier_gen_pkg.sv
// Shared definitions for the PWM carrier generator and the PWM channels.
//   period_t           16-bit unsigned half-period, in clocks
//   PWM_DEFAULT_PERIOD half-period loaded at reset
//   PWM_MIN_PERIOD     smallest accepted half-period
//   clamp_period()     raises a requested half-period to the minimum
package pwm_carrier_gen_pkg;

   typedef logic [15:0] period_t;

   localparam period_t PWM_DEFAULT_PERIOD = 16'd1000;
   localparam period_t PWM_MIN_PERIOD     = 16'd16;

   function automatic period_t clamp_period(input period_t req, input period_t min_p);
      return (req < min_p) ? min_p : req;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a rising-edge detector for the external
// carrier sync. Only built when PWM_CARRIER_EXT_SYNC_EN is defined.
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset, clears all flops
//   async_i  asynchronous level input
//   pulse_o  one-cycle pulse on a synchronised rising edge, driven only by flops
`ifdef PWM_CARRIER_EXT_SYNC_EN
module sync_edge_detect (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign pulse_o = sync_q & ~prev_q;

endmodule
`endif

// File: rtl/pwm_carrier_gen.sv
// PWM carrier generator: a half-period counter with a phase flag, a shadowed
// period register that is committed at each full-cycle boundary, and an
// optional external sync (macro PWM_CARRIER_EXT_SYNC_EN).
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   enable_i                 carrier run enable
//   period_i/period_valid_i  requested half-period and its one-cycle strobe
//   sync_i/sync_offset_i     external sync level and counter load value
//   local_counter_o          position within the current half-period
//   current_period_o         active half-period
//   next_period_o            shadow half-period for the next cycle
//   sync_phase_o             0 = first half, 1 = second half
//   period_start_o           pulse on the first clock of each full cycle
//   period_ack_o             pulse confirming a shadow load
// All outputs come straight from flops.
module pwm_carrier_gen
   import pwm_carrier_gen_pkg::*;
#(
   parameter period_t DEFAULT_PERIOD = PWM_DEFAULT_PERIOD,
   parameter period_t MIN_PERIOD     = PWM_MIN_PERIOD
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic [15:0] period_i,
   input  logic        period_valid_i,
   input  logic        sync_i,
   input  logic [15:0] sync_offset_i,
   output logic [15:0] local_counter_o,
   output logic [15:0] current_period_o,
   output logic [15:0] next_period_o,
   output logic        sync_phase_o,
   output logic        period_start_o,
   output logic        period_ack_o
);

   period_t counter_q, counter_d;
   period_t cur_q, cur_d;
   period_t nxt_q, nxt_d;
   logic    phase_q, phase_d;
   logic    start_q, start_d;
   logic    ack_q, ack_d;
   // Set once the carrier has been running for at least one clock; a low
   // value marks the first active clock after reset or enable.
   logic    run_q, run_d;

`ifdef PWM_CARRIER_EXT_SYNC_EN
   logic sync_pulse;

   sync_edge_detect u_sync_edge_detect (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .async_i (sync_i),
      .pulse_o (sync_pulse)
   );
`else
   logic unused_sync;
   assign unused_sync = ^{sync_i, sync_offset_i};
`endif

   always_comb begin
      counter_d = counter_q;
      phase_d   = phase_q;
      cur_d     = cur_q;
      start_d   = 1'b0;
      run_d     = enable_i;
      // The shadow updates independently; a boundary in the same clock still
      // sees the old nxt_q.
      ack_d     = period_valid_i;
      nxt_d     = period_valid_i ? clamp_period(period_i, MIN_PERIOD) : nxt_q;

      if (!enable_i) begin
         counter_d = '0;
         phase_d   = 1'b0;
      end else if (!run_q) begin
         counter_d = '0;
         phase_d   = 1'b0;
         cur_d     = nxt_q;
         start_d   = 1'b1;
`ifdef PWM_CARRIER_EXT_SYNC_EN
      end else if (sync_pulse) begin
         counter_d = (sync_offset_i < nxt_q) ? sync_offset_i : '0;
         phase_d   = 1'b0;
         cur_d     = nxt_q;
         start_d   = 1'b1;
`endif
      end else if (counter_q >= cur_q - 16'd1) begin
         // >= also catches a counter left above a shortened period.
         counter_d = '0;
         phase_d   = ~phase_q;
         if (phase_q) begin
            cur_d   = nxt_q;
            start_d = 1'b1;
         end
      end else begin
         counter_d = counter_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         counter_q <= '0;
         phase_q   <= 1'b0;
         cur_q     <= DEFAULT_PERIOD;
         nxt_q     <= DEFAULT_PERIOD;
         start_q   <= 1'b0;
         ack_q     <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         counter_q <= counter_d;
         phase_q   <= phase_d;
         cur_q     <= cur_d;
         nxt_q     <= nxt_d;
         start_q   <= start_d;
         ack_q     <= ack_d;
         run_q     <= run_d;
      end
   end

   assign local_counter_o  = counter_q;
   assign current_period_o = cur_q;
   assign next_period_o    = nxt_q;
   assign sync_phase_o     = phase_q;
   assign period_start_o   = start_q;
   assign period_ack_o     = ack_q;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Self-checking bench for pwm_carrier_gen. Outputs are sampled on the falling
// edge; inputs are also changed there. Shadow loads are tracked by a queue.
module tb_pwm_carrier_gen;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        enable_i;
   logic [15:0] period_i;
   logic        period_valid_i;
   logic        sync_i;
   logic [15:0] sync_offset_i;
   logic [15:0] local_counter_o;
   logic [15:0] current_period_o;
   logic [15:0] next_period_o;
   logic        sync_phase_o;
   logic        period_start_o;
   logic        period_ack_o;

   int checks = 0;
   int errors = 0;
   int tnow   = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      int          t;
      logic [15:0] cnt;
      logic        ph;
      logic [15:0] cur;
      logic        st;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   pwm_carrier_gen dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .enable_i         (enable_i),
      .period_i         (period_i),
      .period_valid_i   (period_valid_i),
      .sync_i           (sync_i),
      .sync_offset_i    (sync_offset_i),
      .local_counter_o  (local_counter_o),
      .current_period_o (current_period_o),
      .next_period_o    (next_period_o),
      .sync_phase_o     (sync_phase_o),
      .period_start_o   (period_start_o),
      .period_ack_o     (period_ack_o)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, tnow);
      end
   endtask

   task automatic adv_to(input int t);
      while (tnow < t) begin
         @(negedge clk);
         tnow++;
      end
   endtask

   task automatic strobe(input logic [15:0] p);
      period_i       = p;
      period_valid_i = 1'b1;
      exp_q.push_back((p < 16'd16) ? 16'd16 : p);
      @(negedge clk);
      tnow++;
      period_valid_i = 1'b0;
   endtask

   task automatic chk_state(input string name, input int cnt, input int ph, input int cur,
                            input int st);
      chk({name, "_cnt"}, int'(local_counter_o), cnt);
      chk({name, "_phase"}, int'(sync_phase_o), ph);
      chk({name, "_cur"}, int'(current_period_o), cur);
      chk({name, "_start"}, int'(period_start_o), st);
   endtask

   // Scoreboard: every ack must match the oldest outstanding strobe.
   always @(negedge clk) begin
      if (period_ack_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ack_unexpected: got ack with next=%0d expected no ack", next_period_o);
         end else begin
            chk("ack_next", int'(next_period_o), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      vecs[0] = '{t: 1,    cnt: 16'd0,   ph: 1'b0, cur: 16'd1000, st: 1'b1};
      vecs[1] = '{t: 2,    cnt: 16'd1,   ph: 1'b0, cur: 16'd1000, st: 1'b0};
      vecs[2] = '{t: 1000, cnt: 16'd999, ph: 1'b0, cur: 16'd1000, st: 1'b0};
      vecs[3] = '{t: 1001, cnt: 16'd0,   ph: 1'b1, cur: 16'd1000, st: 1'b0};
      vecs[4] = '{t: 2000, cnt: 16'd999, ph: 1'b1, cur: 16'd1000, st: 1'b0};
      vecs[5] = '{t: 2001, cnt: 16'd0,   ph: 1'b0, cur: 16'd1000, st: 1'b1};
      vecs[6] = '{t: 2002, cnt: 16'd1,   ph: 1'b0, cur: 16'd1000, st: 1'b0};

      rst_ni         = 1'b0;
      enable_i       = 1'b1;
      period_i       = '0;
      period_valid_i = 1'b0;
      sync_i         = 1'b0;
      sync_offset_i  = '0;
      repeat (2) @(negedge clk);
      chk_state("reset", 0, 0, 1000, 0);
      chk("reset_next", int'(next_period_o), 1000);
      chk("reset_ack", int'(period_ack_o), 0);

      rst_ni = 1'b1;
      tnow   = 0;
      foreach (vecs[i]) begin
         adv_to(vecs[i].t);
         chk_state($sformatf("run%0d", vecs[i].t), int'(vecs[i].cnt), int'(vecs[i].ph),
                   int'(vecs[i].cur), int'(vecs[i].st));
      end

      // Shadow load mid first half: current period holds until the boundary.
      strobe(16'd500);
      chk("shadow_next", int'(next_period_o), 500);
      adv_to(3001);
      chk_state("hold_half", 0, 1, 1000, 0);
      adv_to(4000);
      chk_state("hold_end", 999, 1, 1000, 0);
      adv_to(4001);
      chk_state("commit500", 0, 0, 500, 1);
      adv_to(4501);
      chk_state("half500", 0, 1, 500, 0);
      adv_to(5001);
      chk_state("cycle500", 0, 0, 500, 1);

      // Clamp: 5 becomes 16, giving a 32-clock cycle.
      adv_to(5002);
      strobe(16'd5);
      adv_to(6001);
      chk_state("commit16", 0, 0, 16, 1);
      adv_to(6017);
      chk_state("half16", 0, 1, 16, 0);
      adv_to(6032);
      chk_state("end16", 15, 1, 16, 0);
      adv_to(6033);
      chk_state("cycle16", 0, 0, 16, 1);

      // Strobe landing on the boundary clock: old shadow used first.
      adv_to(6064);
      strobe(16'd40);
      chk_state("coinc_old", 0, 0, 16, 1);
      adv_to(6096);
      chk_state("coinc_pre", 15, 1, 16, 0);
      adv_to(6097);
      chk_state("coinc_new", 0, 0, 40, 1);

      // Disable: counter parks at 0, shadow loads still accepted.
      adv_to(6100);
      enable_i = 1'b0;
      adv_to(6101);
      chk_state("dis", 0, 0, 40, 0);
      strobe(16'd20);
      adv_to(6105);
      chk_state("dis_hold", 0, 0, 40, 0);
      chk("dis_next", int'(next_period_o), 20);
      enable_i = 1'b1;
      adv_to(6106);
      chk_state("reenable", 0, 0, 20, 1);
      adv_to(6107);
      chk_state("reenable2", 1, 0, 20, 0);

      // Asynchronous reset mid second half.
      adv_to(6130);
      chk_state("pre_rst", 4, 1, 20, 0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk_state("async_rst", 0, 0, 1000, 0);
      chk("async_rst_next", int'(next_period_o), 1000);
      chk("async_rst_ack", int'(period_ack_o), 0);
      @(negedge clk);
      rst_ni = 1'b1;
      tnow   = 0;
      adv_to(1);
      chk_state("post_rst", 0, 0, 1000, 1);
      adv_to(2000);
      chk_state("post_rst_end", 999, 1, 1000, 0);
      adv_to(2001);
      chk_state("post_rst_cycle", 0, 0, 1000, 1);

      // External sync at counter 700.
      adv_to(2701);
      chk("sync_pre_cnt", int'(local_counter_o), 700);
      sync_offset_i = 16'd300;
      sync_i        = 1'b1;
      adv_to(2703);
      chk("sync_wait_cnt", int'(local_counter_o), 702);
      adv_to(2704);
`ifdef PWM_CARRIER_EXT_SYNC_EN
      chk_state("sync_hit", 300, 0, 1000, 1);
      adv_to(2705);
      chk_state("sync_after", 301, 0, 1000, 0);
`else
      chk_state("sync_ignored", 703, 0, 1000, 0);
      adv_to(2705);
      chk_state("sync_ignored2", 704, 0, 1000, 0);
`endif

      @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
